// File: rtl/uart_frame_deframer.sv
// Frames the uart_rx byte stream into IMG_W x IMG_H grayscale pixels tagged sof/eol/eof,
// with an inter-byte timeout abort and a 2-entry skid buffer towards the filter.
//
// state  | meaning
// HUNT   | discard bytes until SYNC is accepted
// PIXELS | count pixel bytes into the skid until eof or timeout
module uart_frame_deframer #(
  parameter int          IMG_W        = 640,
  parameter int          IMG_H        = 480,
  parameter logic [7:0]  SYNC         = 8'hA5,
  parameter int          TIMEOUT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] axis_rx_data,
  input  logic       axis_rx_vld,
  output logic       axis_rx_rdy,
  output logic [7:0] axis_px_data,
  output logic       axis_px_vld,
  input  logic       axis_px_rdy,
  output logic       px_sof,
  output logic       px_eol,
  output logic       px_eof,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);

  typedef enum logic {HUNT = 1'b0, PIXELS = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    occ_q, occ_d;
  logic [10:0]   ent0_q, ent0_d;
  logic [10:0]   ent1_q, ent1_d;
  logic          run_q, run_d;
  logic          frame_err_q, frame_err_d;

  logic          accept, pop, push;
  logic          is_sof, is_eol, is_eof;
  logic [1:0]    occ_tmp;
  logic [10:0]   new_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      col_q       <= '0;
      row_q       <= '0;
      tmo_q       <= '0;
      occ_q       <= '0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      run_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tmo_q       <= tmo_d;
      occ_q       <= occ_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      run_q       <= run_d;
      frame_err_q <= frame_err_d;
    end
  end

  // rdy depends only on registered state so it never loops through vld
  assign axis_rx_rdy = (state_q == HUNT) ? run_q : (occ_q != 2'd2);
  assign axis_px_vld = (occ_q != 2'd0);
  assign accept      = axis_rx_vld & axis_rx_rdy;
  assign pop         = axis_px_vld & axis_px_rdy;

  assign is_sof  = (col_q == '0) && (row_q == '0);
  assign is_eol  = (col_q == CW'(IMG_W - 1));
  assign is_eof  = is_eol && (row_q == RW'(IMG_H - 1));
  assign new_ent = {axis_rx_data, is_sof, is_eol, is_eof};

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    run_d       = 1'b1;
    push        = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept && (axis_rx_data == SYNC)) begin
          state_d = PIXELS;
          col_d   = '0;
          row_d   = '0;
          tmo_d   = '0;
        end
      end
      PIXELS: begin
        if (accept) begin
          push  = 1'b1;
          tmo_d = '0;
          if (is_eof) begin
            state_d = HUNT;
            col_d   = '0;
            row_d   = '0;
          end else if (is_eol) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
          state_d     = HUNT;
          frame_err_d = 1'b1;
          col_d       = '0;
          row_d       = '0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Skid: entry 0 is the head; a pop shifts entry 1 forward before the push lands
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_tmp = occ_q;
    if (pop) begin
      ent0_d  = ent1_q;
      occ_tmp = occ_q - 2'd1;
    end
    occ_d = occ_tmp;
    if (push) begin
      if (occ_tmp == 2'd0) ent0_d = new_ent;
      else                 ent1_d = new_ent;
      occ_d = occ_tmp + 2'd1;
    end
  end

  assign axis_px_data = ent0_q[10:3];
  assign px_sof       = axis_px_vld & ent0_q[2];
  assign px_eol       = axis_px_vld & ent0_q[1];
  assign px_eof       = axis_px_vld & ent0_q[0];
  assign frame_err    = frame_err_q;
  assign busy         = (state_q == PIXELS);

endmodule

// File: tb/tb_uart_frame_deframer.sv
// Scoreboard bench for uart_frame_deframer: a frame-level reference model fills expected
// queues at byte acceptance, an independent monitor pops and compares on each output transfer.
module tb_uart_frame_deframer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int TMO = 32;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_rdy;
  logic [7:0] px_data;
  logic       px_vld;
  logic       px_rdy;
  logic       px_sof, px_eol, px_eof;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_deframer #(.IMG_W(W), .IMG_H(H), .SYNC(SYNC), .TIMEOUT_CLKS(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .axis_rx_data (rx_data),
    .axis_rx_vld  (rx_vld),
    .axis_rx_rdy  (rx_rdy),
    .axis_px_data (px_data),
    .axis_px_vld  (px_vld),
    .axis_px_rdy  (px_rdy),
    .px_sof       (px_sof),
    .px_eol       (px_eol),
    .px_eof       (px_eof),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
    int         edge_n;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_frame = 0;
  int   pix = 0;
  int   idle = 0;
  bit   force1 = 1;
  bit   force0 = 0;
  bit   lat_mode = 0;
  int   last_err_cyc = -1;
  int   last_acc_edge = -1;
  int   errs_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Frame-level reference: pixel index within the frame gives the tags directly
  task automatic model_step(input bit acc, input logic [7:0] d);
    exp_t e;
    chk("busy", {31'd0, busy}, {31'd0, in_frame});
    if (!in_frame) begin
      if (acc && d == SYNC) begin
        in_frame = 1;
        pix      = 0;
        idle     = 0;
      end
    end else if (acc) begin
      e.d      = d;
      e.sof    = (pix == 0);
      e.eol    = (pix % W == W - 1);
      e.eof    = (pix == W * H - 1);
      e.edge_n = cyc + 1;
      e.lat    = lat_mode;
      exp_q.push_back(e);
      last_acc_edge = cyc + 1;
      pix++;
      idle = 0;
      if (pix == W * H) in_frame = 0;
    end else begin
      idle++;
      if (idle == TMO) begin
        in_frame = 0;
        err_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk);
    rx_vld  = v;
    rx_data = d;
    if (rst) acc = 0;
    else begin
      acc = v && rx_rdy;
      model_step(acc, d);
    end
  endtask

  task automatic idle_n(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(0, 8'($urandom), a);
  endtask

  task automatic send(input logic [7:0] d, input int gap, output int n);
    bit a;
    idle_n(gap);
    n = 0;
    do begin
      drive(1, d, a);
      n++;
    end while (!a && n < 200);
    if (!a) fail("send_stalled");
  endtask

  task automatic send_frame(input logic [7:0] base);
    int n;
    send(SYNC, 0, n);
    for (int i = 0; i < W * H; i++) send(base + 8'(i), 0, n);
  endtask

  // Monitor: owns axis_px.rdy and checks every output transfer and frame_err pulse
  initial begin
    px_rdy = 0;
    forever begin
      @(negedge clk);
      px_rdy = force1 ? 1'b1 : force0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!rst) begin
        if (px_vld && px_rdy) begin
          if (exp_q.size() == 0) fail("unexpected_pixel");
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("px_data", {24'd0, px_data}, {24'd0, e.d});
            chk("px_tags", {29'd0, px_sof, px_eol, px_eof}, {29'd0, e.sof, e.eol, e.eof});
            if (e.lat) chk("px_latency", cyc, e.edge_n);
          end
        end
        if (frame_err) begin
          errs_seen++;
          last_err_cyc = cyc;
          if (err_q.size() == 0) fail("spurious_frame_err");
          else chk("frame_err_time", cyc, err_q.pop_front());
        end else if (err_q.size() > 0 && err_q[0] < cyc) begin
          void'(err_q.pop_front());
          fail("missed_frame_err");
        end
      end
    end
  end

  initial begin
    int n, k, nacc, total, e0;
    bit a;
    logic [7:0] bp_px [8];
    rst = 1; rx_vld = 0; rx_data = 0;
    #2;
    repeat (3) @(negedge clk);
    chk("rst_rx_rdy", {31'd0, rx_rdy}, 0);
    chk("rst_px_vld", {31'd0, px_vld}, 0);
    chk("rst_tags", {29'd0, px_sof, px_eol, px_eof}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    #1 rst = 0;
    @(negedge clk);
    chk("rx_rdy_after_release", {31'd0, rx_rdy}, 1);

    // basic frame with leading junk, exact one-cycle latency
    lat_mode = 1;
    send(8'h00, 0, n);
    send(8'h11, 0, n);
    send_frame(8'h10);
    idle_n(3);
    chk("busy_after_frame", {31'd0, busy}, 0);

    // embedded sync bytes are plain pixels
    send(SYNC, 0, n);
    send(SYNC, 0, n);
    send(SYNC, 0, n);
    for (int i = 1; i < W * H - 1; i++) send(8'(i), 0, n);
    idle_n(3);
    chk("embedded_sync_done", {31'd0, busy}, 0);

    // backpressure: two accepts then rdy held low
    lat_mode = 0;
    for (int i = 0; i < 8; i++) bp_px[i] = 8'h40 + 8'(i);
    send(SYNC, 0, n);
    send(bp_px[0], 0, n);
    send(bp_px[1], 0, n);
    idle_n(1);
    force1 = 0; force0 = 1;
    k = 2; nacc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, bp_px[k], a);
      if (a) begin k++; nacc++; end
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_rx_rdy_low", {31'd0, rx_rdy}, 0);
    force0 = 0; force1 = 1;
    while (k < 8) begin send(bp_px[k], 0, n); k++; end
    idle_n(3);

    // timeout after 3 pixels, then a clean frame
    e0 = errs_seen;
    send(SYNC, 0, n);
    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 0, n);
    idle_n(40);
    chk("tmo_pulses", errs_seen - e0, 1);
    chk("tmo_delay", last_err_cyc - last_acc_edge, TMO);
    chk("tmo_busy", {31'd0, busy}, 0);
    send_frame(8'h70);
    idle_n(3);

    // reset mid-frame with two pixels parked in the skid
    send(SYNC, 0, n);
    for (int i = 0; i < 3; i++) send(8'h80 + 8'(i), 0, n);
    idle_n(1);
    force1 = 0; force0 = 1;
    send(8'h83, 0, n);
    send(8'h84, 0, n);
    @(negedge clk);
    chk("pre_rst_px_vld", {31'd0, px_vld}, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_px_vld", {31'd0, px_vld}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    exp_q.delete(); err_q.delete();
    in_frame = 0; pix = 0; idle = 0;
    force0 = 0; force1 = 1;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    send(8'h11, 0, n);
    send(8'h22, 0, n);
    send_frame(8'h90);
    idle_n(3);

    // back-to-back frames: every byte accepted on its first cycle
    lat_mode = 1;
    total = 0;
    for (int f = 0; f < 2; f++) begin
      send(SYNC, 0, n); total += n;
      for (int i = 0; i < W * H; i++) begin
        send(8'hB0 + 8'(f * 16 + i), 0, n);
        total += n;
      end
    end
    chk("b2b_cycles", total, 2 * (W * H + 1));
    idle_n(3);

    // randomized traffic: junk, frames, random gaps, occasional timeouts
    lat_mode = 0; force1 = 0;
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) send(8'($urandom), $urandom_range(0, 2), n);
      send(SYNC, $urandom_range(0, 2), n);
      for (int i = 0; i < W * H; i++)
        send(8'($urandom), ($urandom_range(0, 19) == 0) ? 45 : $urandom_range(0, 3), n);
    end

    force1 = 1;
    k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && k < 200) begin idle_n(1); k++; end
    chk("drain_pixels", exp_q.size(), 0);
    chk("drain_errs", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_deframer.md
# uart_frame_deframer

Consumes the 8-bit byte stream produced by `uart_rx` and turns it into framed grayscale pixels for the filter pipeline. It hunts for a sync byte and then counts exactly `IMG_W`×`IMG_H` pixel bytes, tagging start-of-frame, end-of-line and end-of-frame. It aborts a stalled frame on an inter-byte timeout. A 2-entry skid buffer decouples `uart_rx` from downstream backpressure.

## Interface
- `IMG_W`, default 640: pixels per line, ≥2.
- `IMG_H`, default 480: lines per frame, ≥1.
- `SYNC`, default 8'hA5: frame start byte.
- `TIMEOUT_CLKS`, default 100000: maximum idle clocks between pixel bytes inside a frame, ≥4.
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `axis_rx`  axis_if slave  8  bytes from `uart_rx`; fields `data`, `vld`, `rdy`.
- `axis_px`  axis_if master  8  pixel stream to the filter; fields `data`, `vld`, `rdy`.
- `px_sof`  out  1  qualifies `axis_px.vld`; marks the first pixel of the frame.
- `px_eol`  out  1  qualifies `axis_px.vld`; marks the last pixel of each line.
- `px_eof`  out  1  qualifies `axis_px.vld`; marks the last pixel of the frame.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by timeout.
- `busy`  out  1  high while in PIXELS.

## Operation
- Handshake: a transfer occurs on a `clk` edge where `vld && rdy`. A master holds `data` and `vld` until accepted.
- FSM states: HUNT, PIXELS.
- HUNT:
  - `axis_rx.rdy`=1; every accepted byte is discarded.
  - An accepted byte == `SYNC` → PIXELS. Clear `col`, `row` and the timeout counter.
- PIXELS:
  - `axis_rx.rdy` = (skid occupancy < 2), driven from registered occupancy only.
  - Each accepted byte is pushed into the skid with tags:
    - sof = (`col`==0 && `row`==0)
    - eol = (`col`==`IMG_W`-1)
    - eof = eol && (`row`==`IMG_H`-1)
  - `col` increments and wraps to 0 at `IMG_W`-1. `row` increments on that wrap.
  - Pushing the eof pixel → HUNT on the same edge. Counters clear.
  - A byte equal to `SYNC` inside PIXELS is ordinary pixel data.
- Timeout:
  - The counter runs only in PIXELS and clears on every accepted byte.
  - When it reaches `TIMEOUT_CLKS`-1 with no accept on that edge: → HUNT, `frame_err`=1 for one cycle, counters clear.
  - Pixels already in the skid are still delivered. The aborted frame has no eof.
- Skid buffer:
  - 2 entries of {data, sof, eol, eof}, FIFO order.
  - `axis_px.vld` = occupancy ≥ 1; head entry drives `data` and the tags.
  - Push and pop on the same edge keep occupancy unchanged.
  - A push is never refused while `rdy`=1.
- Counter widths: `$clog2(IMG_W)`, `$clog2(IMG_H)`, `$clog2(TIMEOUT_CLKS)`.

## Timing
- Reset (async assert, released synchronously to `clk`):
  - state=HUNT, skid empty, all counters 0.
  - `axis_rx.rdy`=0, `axis_px.vld`=0, `px_sof`=`px_eol`=`px_eof`=0, `frame_err`=0, `busy`=0.
  - `axis_rx.rdy` rises on the first `clk` edge after release.
- Reset mid-frame: the frame is dropped immediately and skid contents are discarded. No eof and no `frame_err`.
- Latency: a byte accepted on edge N appears on `axis_px` after edge N (visible in cycle N+1) if the skid was empty.
- Sync byte accepted on edge N: `busy`=1 from cycle N+1. The first pixel can be accepted on edge N+1.
- Throughput: 1 pixel/clk sustained with `axis_px.rdy`=1.
- With `axis_px.rdy`=0: at most 2 bytes are accepted, then `axis_rx.rdy`=0 until a pop frees an entry. `rdy` returns on the cycle after the pop edge.
- eof pushed on edge N: the byte at edge N+1 is already handled by HUNT.
- Timeout and accept on the same edge: the accept wins and the counter clears.

## Test plan
Benches use `IMG_W`=4, `IMG_H`=2, `TIMEOUT_CLKS`=32.

1. Basic frame:
   - Stimulus: bytes 0x00, 0x11, 0xA5, then 8 bytes 0x10..0x17, with `axis_px.rdy`=1.
   - Required: 0x00 and 0x11 are dropped. Output is 0x10..0x17, each one cycle after acceptance.
   - Required tags: sof on 0x10; eol on 0x13 and 0x17; eof on 0x17. `busy` falls after 0x17.
2. Embedded sync: frame with pixel bytes 0xA5,0xA5,0x01,...
   - Required: all 8 pixels are output, including both 0xA5, and the frame is not restarted.
3. Backpressure:
   - Stimulus: `axis_px.rdy`=0 for 10 cycles mid-frame.
   - Required: exactly 2 bytes accepted, then `axis_rx.rdy`=0. After `rdy`=1, order and tags are intact with no loss or duplication.
4. Timeout:
   - Stimulus: sync, 3 pixels, then idle 40 cycles.
   - Required: `frame_err` pulses once, 32 clocks after the 3rd accept. `busy`=0 after the pulse.
   - Required: a following sync plus 8 pixels gives sof on the first of them.
5. Reset mid-frame:
   - Stimulus: assert `rst` asynchronously after 5 pixels, with 2 held in the skid.
   - Required: `axis_px.vld`=0 immediately. After release, stray bytes are discarded until 0xA5.
6. Back-to-back frames:
   - Stimulus: sync, 8 pixels, then sync on the very next cycle, then 8 pixels, with `axis_px.rdy`=1.
   - Required: two complete frames with no bubble beyond the sync byte cycle.
